// File: rtl/decision_tree_engine.sv
// decision_tree_engine: programmable heap-indexed decision tree walked one node per clock
// through a single shared comparator, with valid/ready input and output handshakes.
module decision_tree_engine #(
  parameter int unsigned FEATURE_WIDTH = 8,
  parameter int unsigned NUM_FEATURES  = 7,
  parameter int unsigned MAX_DEPTH     = 3,
  parameter int unsigned CLASS_WIDTH   = 2,
  localparam int unsigned NUM_NODES    = (1 << MAX_DEPTH) - 1,
  localparam int unsigned NODE_AW      = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1,
  localparam int unsigned FIDX_W       = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [NUM_FEATURES*FEATURE_WIDTH-1:0] in_features,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [CLASS_WIDTH-1:0]                out_class,
  output logic [NODE_AW-1:0]                    out_node,
  output logic [NODE_AW-1:0]                    out_depth,
  output logic                                  out_err,
  input  logic                                  cfg_we,
  input  logic [NODE_AW-1:0]                    cfg_addr,
  input  logic [FIDX_W-1:0]                     cfg_fidx,
  input  logic [FEATURE_WIDTH-1:0]              cfg_thresh,
  input  logic                                  cfg_leaf,
  input  logic [CLASS_WIDTH-1:0]                cfg_class,
  output logic                                  cfg_busy
);

  localparam int unsigned FV_W     = NUM_FEATURES * FEATURE_WIDTH;
  // Table is sized to the full address space so any node index reads a defined entry.
  localparam int unsigned TBL_SIZE = 1 << NODE_AW;

  typedef struct packed {
    logic                     leaf;
    logic [CLASS_WIDTH-1:0]   cls;
    logic [FIDX_W-1:0]        fidx;
    logic [FEATURE_WIDTH-1:0] thresh;
  } node_t;

  localparam node_t RST_NODE = '{leaf: 1'b1, cls: '0, fidx: '0, thresh: '0};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WALK = 2'd1, S_DONE = 2'd2} state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  node_t                    r_table [TBL_SIZE];
  logic [FV_W-1:0]          r_features;
  logic [NODE_AW-1:0]       r_node;
  logic [NODE_AW-1:0]       r_depth;
  logic                     r_in_ready;
  logic                     r_busy;
  logic                     r_out_valid;
  logic                     r_out_err;
  logic [CLASS_WIDTH-1:0]   r_out_class;
  logic [NODE_AW-1:0]       r_out_node;
  logic [NODE_AW-1:0]       r_out_depth;

  node_t                    w_cur;
  logic [FEATURE_WIDTH-1:0] w_feat;
  logic                     w_fidx_bad;
  logic                     w_go_left;
  logic [NODE_AW:0]         w_child;
  logic                     w_child_bad;
  logic                     w_accept;
  logic                     w_cfg_wr;
  logic                     w_feat_ld;
  logic [NODE_AW-1:0]       w_node_nxt;
  logic [NODE_AW-1:0]       w_depth_nxt;
  logic                     w_out_valid_nxt;
  logic                     w_out_err_nxt;
  logic [CLASS_WIDTH-1:0]   w_out_class_nxt;
  logic [NODE_AW-1:0]       w_out_node_nxt;
  logic [NODE_AW-1:0]       w_out_depth_nxt;

  assign in_ready  = r_in_ready;
  assign cfg_busy  = r_busy;
  assign out_valid = r_out_valid;
  assign out_err   = r_out_err;
  assign out_class = r_out_class;
  assign out_node  = r_out_node;
  assign out_depth = r_out_depth;

  assign w_accept    = in_valid && r_in_ready;
  assign w_cfg_wr    = cfg_we && (r_state == S_IDLE) && (cfg_addr < NODE_AW'(NUM_NODES));
  assign w_cur       = r_table[r_node];
  assign w_fidx_bad  = {1'b0, w_cur.fidx} >= (FIDX_W+1)'(NUM_FEATURES);
  assign w_go_left   = w_feat < w_cur.thresh;
  assign w_child     = {r_node, 1'b0} + (NODE_AW+1)'(w_go_left ? 1 : 2);
  assign w_child_bad = w_child >= (NODE_AW+1)'(NUM_NODES);

  // Shared comparator operand: select the feature named by the current node.
  always_comb begin
    w_feat = '0;
    for (int unsigned i = 0; i < NUM_FEATURES; i++) begin
      if (w_cur.fidx == FIDX_W'(i)) w_feat = r_features[i*FEATURE_WIDTH +: FEATURE_WIDTH];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_WALK;
      S_WALK:  if (w_cur.leaf || w_fidx_bad || w_child_bad) w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output/datapath decode: walk step, result capture and handshake.
  always_comb begin
    w_feat_ld       = 1'b0;
    w_node_nxt      = r_node;
    w_depth_nxt     = r_depth;
    w_out_valid_nxt = r_out_valid;
    w_out_err_nxt   = r_out_err;
    w_out_class_nxt = r_out_class;
    w_out_node_nxt  = r_out_node;
    w_out_depth_nxt = r_out_depth;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_feat_ld   = 1'b1;
          w_node_nxt  = '0;
          w_depth_nxt = '0;
        end
      end
      S_WALK: begin
        if (w_cur.leaf) begin
          w_out_valid_nxt = 1'b1;
          w_out_err_nxt   = 1'b0;
          w_out_class_nxt = w_cur.cls;
          w_out_node_nxt  = r_node;
          w_out_depth_nxt = r_depth;
        end else if (w_fidx_bad || w_child_bad) begin
          w_out_valid_nxt = 1'b1;
          w_out_err_nxt   = 1'b1;
          w_out_class_nxt = '0;
          w_out_node_nxt  = r_node;
          w_out_depth_nxt = r_depth;
        end else begin
          w_node_nxt  = w_child[NODE_AW-1:0];
          w_depth_nxt = r_depth + NODE_AW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) w_out_valid_nxt = 1'b0;
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_features  <= '0;
      r_node      <= '0;
      r_depth     <= '0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_err   <= 1'b0;
      r_out_class <= '0;
      r_out_node  <= '0;
      r_out_depth <= '0;
    end else begin
      if (w_feat_ld) r_features <= in_features;
      r_node      <= w_node_nxt;
      r_depth     <= w_depth_nxt;
      r_in_ready  <= (w_state_nxt == S_IDLE);
      r_busy      <= (w_state_nxt != S_IDLE);
      r_out_valid <= w_out_valid_nxt;
      r_out_err   <= w_out_err_nxt;
      r_out_class <= w_out_class_nxt;
      r_out_node  <= w_out_node_nxt;
      r_out_depth <= w_out_depth_nxt;
    end
  end

  // Node table: cleared to class-0 leaves on reset, writable only while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < TBL_SIZE; i++) r_table[i] <= RST_NODE;
    end else if (w_cfg_wr) begin
      r_table[cfg_addr] <= '{leaf: cfg_leaf, cls: cfg_class, fidx: cfg_fidx, thresh: cfg_thresh};
    end
  end

endmodule

// File: tb/tb_decision_tree_engine.sv
// tb_decision_tree_engine: directed scenario tests for decision_tree_engine.
module tb_decision_tree_engine;

  localparam int unsigned FW  = 8;
  localparam int unsigned NF  = 7;
  localparam int unsigned NAW = 3;
  localparam int unsigned FIW = 3;
  localparam int unsigned CW  = 2;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [NF*FW-1:0] in_features;
  logic            out_valid;
  logic            out_ready;
  logic [CW-1:0]   out_class;
  logic [NAW-1:0]  out_node;
  logic [NAW-1:0]  out_depth;
  logic            out_err;
  logic            cfg_we;
  logic [NAW-1:0]  cfg_addr;
  logic [FIW-1:0]  cfg_fidx;
  logic [FW-1:0]   cfg_thresh;
  logic            cfg_leaf;
  logic [CW-1:0]   cfg_class;
  logic            cfg_busy;

  int tests_run;
  int tests_failed;

  decision_tree_engine #(
    .FEATURE_WIDTH(FW), .NUM_FEATURES(NF), .MAX_DEPTH(3), .CLASS_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_features(in_features),
    .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
    .out_node(out_node), .out_depth(out_depth), .out_err(out_err),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_fidx(cfg_fidx),
    .cfg_thresh(cfg_thresh), .cfg_leaf(cfg_leaf), .cfg_class(cfg_class),
    .cfg_busy(cfg_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NF*FW-1:0] fv(input logic [FW-1:0] f0, f1, f2, f3, f4, f5, f6);
    return {f6, f5, f4, f3, f2, f1, f0};
  endfunction

  task automatic cfg_write(input logic [NAW-1:0] a, input logic [FIW-1:0] f,
                           input logic [FW-1:0] t, input logic lf, input logic [CW-1:0] c);
    cfg_addr = a; cfg_fidx = f; cfg_thresh = t; cfg_leaf = lf; cfg_class = c; cfg_we = 1'b1;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  // Present a vector for one edge, then scramble the bus to show it was latched.
  task automatic send(input logic [NF*FW-1:0] v);
    in_features = v; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_features = '1;
  endtask

  // Cycles from accept until out_valid, bounded at 20.
  task automatic wait_out(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic drain;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic program_tree;
    cfg_write(3'd0, 3'd0, 8'd10, 1'b0, 2'd0);
    cfg_write(3'd1, 3'd1, 8'd11, 1'b0, 2'd0);
    cfg_write(3'd2, 3'd2, 8'd12, 1'b0, 2'd0);
    for (int i = 3; i < 7; i++) cfg_write(3'(i), 3'd0, 8'd0, 1'b1, 2'(i - 3));
  endtask

  task automatic test_reset;
    int n;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_out_valid: got %0d expected 0", out_valid); end
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_in_ready: got %0d expected 1", in_ready); end
    tests_run++; if (cfg_busy !== 1'b0) begin tests_failed++; $display("FAIL rst_cfg_busy: got %0d expected 0", cfg_busy); end
    tests_run++; if ({out_class, out_node, out_depth, out_err} !== '0) begin tests_failed++; $display("FAIL rst_outputs: got class=%0d node=%0d depth=%0d err=%0d expected all 0", out_class, out_node, out_depth, out_err); end
    send(fv(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7));
    wait_out(n);
    tests_run++; if (n !== 1) begin tests_failed++; $display("FAIL rst_leaf_latency: got %0d expected 1", n); end
    tests_run++; if ({out_class, out_node, out_depth, out_err} !== '0) begin tests_failed++; $display("FAIL rst_leaf_result: got class=%0d node=%0d depth=%0d err=%0d expected all 0", out_class, out_node, out_depth, out_err); end
    drain;
  endtask

  task automatic test_full_depth;
    int n;
    program_tree();
    send(fv(8'd5, 8'd20, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0));
    wait_out(n);
    tests_run++; if (n !== 3) begin tests_failed++; $display("FAIL walk_a_latency: got %0d expected 3", n); end
    tests_run++; if (out_class !== 2'd1 || out_node !== 3'd4 || out_depth !== 3'd2 || out_err !== 1'b0) begin tests_failed++; $display("FAIL walk_a_result: got class=%0d node=%0d depth=%0d err=%0d expected 1/4/2/0", out_class, out_node, out_depth, out_err); end
    drain;
    send(fv(8'd10, 8'd0, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0));
    wait_out(n);
    tests_run++; if (n !== 3) begin tests_failed++; $display("FAIL walk_b_latency: got %0d expected 3", n); end
    tests_run++; if (out_class !== 2'd2 || out_node !== 3'd5 || out_depth !== 3'd2 || out_err !== 1'b0) begin tests_failed++; $display("FAIL walk_b_result: got class=%0d node=%0d depth=%0d err=%0d expected 2/5/2/0", out_class, out_node, out_depth, out_err); end
    drain;
  endtask

  task automatic test_backpressure;
    int n;
    send(fv(8'd5, 8'd20, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0));
    wait_out(n);
    tests_run++; if (n !== 3) begin tests_failed++; $display("FAIL bp_latency: got %0d expected 3", n); end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      tests_run++; if (out_valid !== 1'b1 || out_class !== 2'd1 || out_node !== 3'd4 || out_depth !== 3'd2) begin tests_failed++; $display("FAIL bp_hold_%0d: got valid=%0d class=%0d node=%0d depth=%0d expected 1/1/4/2", c, out_valid, out_class, out_node, out_depth); end
      tests_run++; if (in_ready !== 1'b0 || cfg_busy !== 1'b1) begin tests_failed++; $display("FAIL bp_flags_%0d: got in_ready=%0d busy=%0d expected 0/1", c, in_ready, cfg_busy); end
    end
    drain;
    tests_run++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || cfg_busy !== 1'b0) begin tests_failed++; $display("FAIL bp_release: got valid=%0d in_ready=%0d busy=%0d expected 0/1/0", out_valid, in_ready, cfg_busy); end
    tests_run++; if (out_class !== 2'd1 || out_node !== 3'd4) begin tests_failed++; $display("FAIL bp_sticky: got class=%0d node=%0d expected 1/4", out_class, out_node); end
  endtask

  task automatic test_err_child;
    int n;
    // Node 6 sits on the last level; making it internal forces an out-of-range child.
    cfg_write(3'd6, 3'd0, 8'd0, 1'b0, 2'd3);
    send(fv(8'd200, 8'd0, 8'd50, 8'd0, 8'd0, 8'd0, 8'd0));
    wait_out(n);
    tests_run++; if (n !== 3) begin tests_failed++; $display("FAIL err_child_latency: got %0d expected 3", n); end
    tests_run++; if (out_err !== 1'b1 || out_class !== 2'd0 || out_node !== 3'd6) begin tests_failed++; $display("FAIL err_child_result: got err=%0d class=%0d node=%0d expected 1/0/6", out_err, out_class, out_node); end
    drain;
    cfg_write(3'd6, 3'd0, 8'd0, 1'b1, 2'd3);
  endtask

  task automatic test_err_fidx;
    int n;
    cfg_write(3'd0, 3'd7, 8'd10, 1'b0, 2'd0);
    send(fv(8'd5, 8'd20, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0));
    wait_out(n);
    tests_run++; if (n !== 1) begin tests_failed++; $display("FAIL err_fidx_latency: got %0d expected 1", n); end
    tests_run++; if (out_err !== 1'b1 || out_class !== 2'd0 || out_node !== 3'd0 || out_depth !== 3'd0) begin tests_failed++; $display("FAIL err_fidx_result: got err=%0d class=%0d node=%0d depth=%0d expected 1/0/0/0", out_err, out_class, out_node, out_depth); end
    drain;
    // Highest legal feature index still compares normally.
    cfg_write(3'd0, 3'd6, 8'd10, 1'b0, 2'd0);
    send(fv(8'd99, 8'd20, 8'd0, 8'd0, 8'd0, 8'd0, 8'd3));
    wait_out(n);
    tests_run++; if (out_err !== 1'b0 || out_node !== 3'd4 || out_class !== 2'd1) begin tests_failed++; $display("FAIL fidx_max_result: got err=%0d node=%0d class=%0d expected 0/4/1", out_err, out_node, out_class); end
    drain;
    cfg_write(3'd0, 3'd0, 8'd10, 1'b0, 2'd0);
  endtask

  task automatic test_cfg_gating;
    int n;
    send(fv(8'd5, 8'd20, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0));
    cfg_write(3'd4, 3'd0, 8'd0, 1'b1, 2'd3);
    wait_out(n);
    tests_run++; if (out_class !== 2'd1 || out_node !== 3'd4) begin tests_failed++; $display("FAIL gate_walk_same: got class=%0d node=%0d expected 1/4", out_class, out_node); end
    drain;
    send(fv(8'd5, 8'd20, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0));
    wait_out(n);
    tests_run++; if (out_class !== 2'd1) begin tests_failed++; $display("FAIL gate_walk_next: got %0d expected 1", out_class); end
    drain;
    // Write and accept on the same idle edge: the new entry is used.
    cfg_addr = 3'd4; cfg_fidx = 3'd0; cfg_thresh = 8'd0; cfg_leaf = 1'b1; cfg_class = 2'd3; cfg_we = 1'b1;
    send(fv(8'd5, 8'd20, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0));
    cfg_we = 1'b0;
    wait_out(n);
    tests_run++; if (out_class !== 2'd3 || out_node !== 3'd4) begin tests_failed++; $display("FAIL gate_idle_same: got class=%0d node=%0d expected 3/4", out_class, out_node); end
    // Write while holding a result is dropped.
    cfg_write(3'd4, 3'd0, 8'd0, 1'b1, 2'd0);
    drain;
    send(fv(8'd5, 8'd20, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0));
    wait_out(n);
    tests_run++; if (out_class !== 2'd3) begin tests_failed++; $display("FAIL gate_done: got %0d expected 3", out_class); end
    drain;
  endtask

  task automatic test_reset_mid_walk;
    int n;
    int seen;
    send(fv(8'd5, 8'd20, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests_run++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || cfg_busy !== 1'b0) begin tests_failed++; $display("FAIL midrst_flags: got valid=%0d in_ready=%0d busy=%0d expected 0/1/0", out_valid, in_ready, cfg_busy); end
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    tests_run++; if (seen !== 0) begin tests_failed++; $display("FAIL midrst_no_output: got %0d valid cycles expected 0", seen); end
    send(fv(8'd5, 8'd20, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0));
    wait_out(n);
    tests_run++; if (n !== 1 || out_node !== 3'd0 || out_class !== 2'd0 || out_err !== 1'b0) begin tests_failed++; $display("FAIL midrst_table_cleared: got lat=%0d node=%0d class=%0d err=%0d expected 1/0/0/0", n, out_node, out_class, out_err); end
    drain;
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    rst = 1'b1; in_valid = 1'b0; in_features = '0; out_ready = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_fidx = '0; cfg_thresh = '0; cfg_leaf = 1'b0; cfg_class = '0;
    test_reset();
    test_full_depth();
    test_backpressure();
    test_err_child();
    test_err_fidx();
    test_cfg_gating();
    test_reset_mid_walk();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
